// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, FSM states,
// one-hot opcode classes, ALU op codes and datapath select codes.
package multicycle_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    // One-hot class vector, MSB to LSB: {R, ADDI, LW, SW, BEQ, J, ILLEGAL}
    typedef logic [6:0] opclass_t;
    localparam opclass_t CLS_R    = 7'b1000000;
    localparam opclass_t CLS_ADDI = 7'b0100000;
    localparam opclass_t CLS_LW   = 7'b0010000;
    localparam opclass_t CLS_SW   = 7'b0001000;
    localparam opclass_t CLS_BEQ  = 7'b0000100;
    localparam opclass_t CLS_J    = 7'b0000010;
    localparam opclass_t CLS_ILL  = 7'b0000001;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd3;

    localparam logic [1:0] SRCB_RT    = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_SHIMM = 2'd3;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam int WAIT_W = 8;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_WB_R   = 4'd4,
        S_EXEC_I = 4'd5,
        S_WB_I   = 4'd6,
        S_ADDR   = 4'd7,
        S_MEM_RD = 4'd8,
        S_WB_MEM = 4'd9,
        S_MEM_WR = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_TRAP   = 4'd13
    } state_e;

endpackage

// File: rtl/control_opclass.sv
// Maps the instruction-register opcode field onto a one-hot instruction class.
module control_opclass
    import multicycle_pkg::*;
(
    input  logic [5:0] op_i,
    output opclass_t   class_o
);

    // Opcode to class lookup; every unknown opcode is ILLEGAL
    always_comb begin
        class_o = CLS_ILL;
        case (op_i)
            OP_R:    class_o = CLS_R;
            OP_ADDI: class_o = CLS_ADDI;
            OP_LW:   class_o = CLS_LW;
            OP_SW:   class_o = CLS_SW;
            OP_BEQ:  class_o = CLS_BEQ;
            OP_J:    class_o = CLS_J;
            default: class_o = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with a memory-wait timeout and retired-instruction counter.
// Define MULTICYCLE_CONTROL_TRAP_EN to trap illegal opcodes and expose illegal_o.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int ALUOP_W  = 2,
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [5:0]         op_i,
    input  logic               mem_ready_i,
    output logic               pc_write_o,
    output logic               pc_write_cond_o,
    output logic [1:0]         pc_src_o,
    output logic               ir_write_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               i_or_d_o,
    output logic               reg_dst_o,
    output logic               reg_write_o,
    output logic               mem_to_reg_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               busy_o,
    output logic               mem_err_o,
    output logic [CNT_W-1:0]   retired_o
`ifdef MULTICYCLE_CONTROL_TRAP_EN
    ,
    output logic               illegal_o
`endif
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    opclass_t          cls_s;
    logic              timeout_s;
    logic [1:0]        alu_op_s;

    control_opclass u_opclass (
        .op_i    (op_i),
        .class_o (cls_s)
    );

    assign timeout_s = (wait_q == WAIT_LAST);

    // Next-state, wait-counter, error-flag and retire-counter logic
    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        err_d     = err_q;
        retired_d = retired_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FETCH;
                    err_d   = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
                // The counter only runs while an access is outstanding
                if (mem_ready_i) begin
                    if (state_q == S_FETCH) begin
                        state_d = S_DECODE;
                    end else if (state_q == S_MEM_RD) begin
                        state_d = S_WB_MEM;
                    end else begin
                        state_d   = S_FETCH;
                        retired_d = retired_q + CNT_ONE;
                    end
                end else if (timeout_s) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                case (cls_s)
                    CLS_R:          state_d = S_EXEC_R;
                    CLS_ADDI:       state_d = S_EXEC_I;
                    CLS_LW, CLS_SW: state_d = S_ADDR;
                    CLS_BEQ:        state_d = S_BRANCH;
                    CLS_J:          state_d = S_JUMP;
`ifdef MULTICYCLE_CONTROL_TRAP_EN
                    default:        state_d = S_TRAP;
`else
                    default:        state_d = S_FETCH;
`endif
                endcase
            end
            S_EXEC_R: state_d = S_WB_R;
            S_EXEC_I: state_d = S_WB_I;
            S_ADDR:   state_d = (cls_s == CLS_SW) ? S_MEM_WR : S_MEM_RD;
            S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: begin
                state_d   = S_FETCH;
                retired_d = retired_q + CNT_ONE;
            end
`ifdef MULTICYCLE_CONTROL_TRAP_EN
            S_TRAP:   state_d = S_TRAP;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            err_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
            retired_q <= retired_d;
        end
    end

    // Moore output decode; only the FETCH load strobes follow mem_ready_i
    always_comb begin
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        pc_src_o        = PC_SRC_ALU;
        ir_write_o      = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        i_or_d_o        = 1'b0;
        reg_dst_o       = 1'b0;
        reg_write_o     = 1'b0;
        mem_to_reg_o    = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = SRCB_RT;
        alu_op_s        = ALU_ADD;
`ifdef MULTICYCLE_CONTROL_TRAP_EN
        illegal_o       = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            S_DECODE: alu_src_b_o = SRCB_SHIMM;
            S_EXEC_R: begin
                alu_src_a_o = 1'b1;
                alu_op_s    = ALU_FUNCT;
            end
            S_WB_R: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
            end
            S_EXEC_I, S_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
            end
            S_WB_I: reg_write_o = 1'b1;
            S_MEM_RD: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
            end
            S_WB_MEM: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_o = 1'b1;
                i_or_d_o    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o     = 1'b1;
                alu_op_s        = ALU_SUB;
                pc_write_cond_o = 1'b1;
                pc_src_o        = PC_SRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write_o = 1'b1;
                pc_src_o   = PC_SRC_JUMP;
            end
`ifdef MULTICYCLE_CONTROL_TRAP_EN
            S_TRAP:  illegal_o = 1'b1;
`endif
            default: begin
            end
        endcase
        busy_o = (state_q != S_IDLE);
    end

    assign alu_op_o  = ALUOP_W'(alu_op_s);
    assign mem_err_o = err_q;
    assign retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle vectors pass through an expected-value queue,
// followed by hand-written timeout, counter-wrap and asynchronous-reset sequences.
module tb_multicycle_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ILL  = 6'b111111;

    // Control word: {pcw, pcwc, pc_src[2], irw, mrd, mwr, iord, rdst, rw, m2r, srca, srcb[2], aluop[2]}
    localparam logic [15:0] C_IDLE = 16'h0000;
    localparam logic [15:0] C_FETW = 16'h0404;
    localparam logic [15:0] C_FETR = 16'h8C04;
    localparam logic [15:0] C_DEC  = 16'h000C;
    localparam logic [15:0] C_EXR  = 16'h0013;
    localparam logic [15:0] C_WBR  = 16'h00C0;
    localparam logic [15:0] C_EXI  = 16'h0018;
    localparam logic [15:0] C_WBI  = 16'h0040;
    localparam logic [15:0] C_MRD  = 16'h0500;
    localparam logic [15:0] C_WBM  = 16'h0060;
    localparam logic [15:0] C_MWR  = 16'h0300;
    localparam logic [15:0] C_BR   = 16'h5011;
    localparam logic [15:0] C_JMP  = 16'hA000;

    typedef struct {
        logic        st;
        logic [5:0]  op;
        logic        rdy;
        logic [15:0] ctl;
        logic        busy;
        logic        err;
        logic [3:0]  ret;
        logic        ill;
        logic [63:0] tag;
    } vec_t;

    logic       clk_i, rst_i, start_i, mem_ready_i;
    logic [5:0] op_i;
    logic       pc_write_o, pc_write_cond_o, ir_write_o, mem_read_o, mem_write_o, i_or_d_o;
    logic       reg_dst_o, reg_write_o, mem_to_reg_o, alu_src_a_o, busy_o, mem_err_o;
    logic [1:0] pc_src_o, alu_src_b_o, alu_op_o;
    logic [3:0] retired_o;
    logic [15:0] ctl_s;
    logic        ill_s;

    vec_t exp_q[$];
    vec_t tbl[31];
    int   n_checks = 0;
    int   n_fail   = 0;

    multicycle_control #(.ALUOP_W(2), .CNT_W(4), .WAIT_MAX(15)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .op_i            (op_i),
        .mem_ready_i     (mem_ready_i),
        .pc_write_o      (pc_write_o),
        .pc_write_cond_o (pc_write_cond_o),
        .pc_src_o        (pc_src_o),
        .ir_write_o      (ir_write_o),
        .mem_read_o      (mem_read_o),
        .mem_write_o     (mem_write_o),
        .i_or_d_o        (i_or_d_o),
        .reg_dst_o       (reg_dst_o),
        .reg_write_o     (reg_write_o),
        .mem_to_reg_o    (mem_to_reg_o),
        .alu_src_a_o     (alu_src_a_o),
        .alu_src_b_o     (alu_src_b_o),
        .alu_op_o        (alu_op_o),
        .busy_o          (busy_o),
        .mem_err_o       (mem_err_o),
        .retired_o       (retired_o)
`ifdef MULTICYCLE_CONTROL_TRAP_EN
        ,
        .illegal_o       (ill_s)
`endif
    );

`ifndef MULTICYCLE_CONTROL_TRAP_EN
    assign ill_s = 1'b0;
`endif

    assign ctl_s = {pc_write_o, pc_write_cond_o, pc_src_o, ir_write_o, mem_read_o, mem_write_o,
                    i_or_d_o, reg_dst_o, reg_write_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o};

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(input logic st, input logic [5:0] op, input logic rdy,
                                input logic [15:0] ctl, input logic busy, input logic err,
                                input logic [3:0] ret, input logic ill, input logic [63:0] tag);
        vec_t v;
        v.st = st; v.op = op; v.rdy = rdy; v.ctl = ctl; v.busy = busy;
        v.err = err; v.ret = ret; v.ill = ill; v.tag = tag;
        return v;
    endfunction

    task automatic check_out();
        vec_t        e;
        logic [22:0] got, want;
        e    = exp_q.pop_front();
        got  = {ctl_s, busy_o, mem_err_o, retired_o, ill_s};
        want = {e.ctl, e.busy, e.err, e.ret, e.ill};
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got ctl=%h busy=%b err=%b ret=%0d ill=%b, expected ctl=%h busy=%b err=%b ret=%0d ill=%b",
                     e.tag, ctl_s, busy_o, mem_err_o, retired_o, ill_s,
                     e.ctl, e.busy, e.err, e.ret, e.ill);
        end
    endtask

    task automatic drive(input vec_t v);
        @(posedge clk_i);
        #1;
        start_i     = v.st;
        op_i        = v.op;
        mem_ready_i = v.rdy;
        exp_q.push_back(v);
        @(negedge clk_i);
        check_out();
    endtask

    task automatic rst_pulse();
        @(posedge clk_i);
        #1;
        rst_i       = 1'b1;
        start_i     = 1'b0;
        mem_ready_i = 1'b0;
        exp_q.push_back(mk(1'b0, op_i, 1'b0, C_IDLE, 1'b0, 1'b0, 4'd0, 1'b0, "reset   "));
        @(negedge clk_i);
        check_out();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; start_i = 1'b0; op_i = 6'd0; mem_ready_i = 1'b0;

        tbl[0]  = mk(1'b1, OP_R,    1'b1, C_IDLE, 1'b0, 1'b0, 4'd0, 1'b0, "idle_st ");
        tbl[1]  = mk(1'b0, OP_R,    1'b1, C_FETR, 1'b1, 1'b0, 4'd0, 1'b0, "r_fetch ");
        tbl[2]  = mk(1'b0, OP_R,    1'b0, C_DEC,  1'b1, 1'b0, 4'd0, 1'b0, "r_decode");
        tbl[3]  = mk(1'b0, OP_R,    1'b1, C_EXR,  1'b1, 1'b0, 4'd0, 1'b0, "r_exec  ");
        tbl[4]  = mk(1'b1, OP_R,    1'b0, C_WBR,  1'b1, 1'b0, 4'd0, 1'b0, "r_wb    ");
        tbl[5]  = mk(1'b0, OP_ADDI, 1'b0, C_FETW, 1'b1, 1'b0, 4'd1, 1'b0, "i_fwait ");
        tbl[6]  = mk(1'b0, OP_ADDI, 1'b1, C_FETR, 1'b1, 1'b0, 4'd1, 1'b0, "i_fetch ");
        tbl[7]  = mk(1'b0, OP_ADDI, 1'b0, C_DEC,  1'b1, 1'b0, 4'd1, 1'b0, "i_decode");
        tbl[8]  = mk(1'b0, OP_ADDI, 1'b0, C_EXI,  1'b1, 1'b0, 4'd1, 1'b0, "i_exec  ");
        tbl[9]  = mk(1'b0, OP_ADDI, 1'b0, C_WBI,  1'b1, 1'b0, 4'd1, 1'b0, "i_wb    ");
        tbl[10] = mk(1'b0, OP_LW,   1'b1, C_FETR, 1'b1, 1'b0, 4'd2, 1'b0, "lw_fetch");
        tbl[11] = mk(1'b0, OP_LW,   1'b0, C_DEC,  1'b1, 1'b0, 4'd2, 1'b0, "lw_dec  ");
        tbl[12] = mk(1'b0, OP_LW,   1'b1, C_EXI,  1'b1, 1'b0, 4'd2, 1'b0, "lw_addr ");
        tbl[13] = mk(1'b0, OP_LW,   1'b0, C_MRD,  1'b1, 1'b0, 4'd2, 1'b0, "lw_wait1");
        tbl[14] = mk(1'b0, OP_LW,   1'b0, C_MRD,  1'b1, 1'b0, 4'd2, 1'b0, "lw_wait2");
        tbl[15] = mk(1'b0, OP_LW,   1'b0, C_MRD,  1'b1, 1'b0, 4'd2, 1'b0, "lw_wait3");
        tbl[16] = mk(1'b0, OP_LW,   1'b1, C_MRD,  1'b1, 1'b0, 4'd2, 1'b0, "lw_rdy  ");
        tbl[17] = mk(1'b0, OP_LW,   1'b0, C_WBM,  1'b1, 1'b0, 4'd2, 1'b0, "lw_wb   ");
        tbl[18] = mk(1'b0, OP_BEQ,  1'b1, C_FETR, 1'b1, 1'b0, 4'd3, 1'b0, "b_fetch ");
        tbl[19] = mk(1'b0, OP_BEQ,  1'b0, C_DEC,  1'b1, 1'b0, 4'd3, 1'b0, "b_decode");
        tbl[20] = mk(1'b0, OP_BEQ,  1'b0, C_BR,   1'b1, 1'b0, 4'd3, 1'b0, "b_branch");
        tbl[21] = mk(1'b0, OP_J,    1'b1, C_FETR, 1'b1, 1'b0, 4'd4, 1'b0, "j_fetch ");
        tbl[22] = mk(1'b0, OP_J,    1'b0, C_DEC,  1'b1, 1'b0, 4'd4, 1'b0, "j_decode");
        tbl[23] = mk(1'b0, OP_J,    1'b0, C_JMP,  1'b1, 1'b0, 4'd4, 1'b0, "j_jump  ");
        tbl[24] = mk(1'b0, OP_SW,   1'b1, C_FETR, 1'b1, 1'b0, 4'd5, 1'b0, "sw_fetch");
        tbl[25] = mk(1'b0, OP_SW,   1'b0, C_DEC,  1'b1, 1'b0, 4'd5, 1'b0, "sw_dec  ");
        tbl[26] = mk(1'b0, OP_SW,   1'b0, C_EXI,  1'b1, 1'b0, 4'd5, 1'b0, "sw_addr ");
        tbl[27] = mk(1'b0, OP_SW,   1'b0, C_MWR,  1'b1, 1'b0, 4'd5, 1'b0, "sw_wait ");
        tbl[28] = mk(1'b0, OP_SW,   1'b1, C_MWR,  1'b1, 1'b0, 4'd5, 1'b0, "sw_rdy  ");
        tbl[29] = mk(1'b0, OP_ILL,  1'b1, C_FETR, 1'b1, 1'b0, 4'd6, 1'b0, "il_fetch");
        tbl[30] = mk(1'b0, OP_ILL,  1'b0, C_DEC,  1'b1, 1'b0, 4'd6, 1'b0, "il_dec  ");

        rst_pulse();
        for (int i = 0; i < 31; i++) drive(tbl[i]);

`ifdef MULTICYCLE_CONTROL_TRAP_EN
        drive(mk(1'b0, OP_ILL, 1'b1, C_IDLE, 1'b1, 1'b0, 4'd6, 1'b1, "il_trap "));
        drive(mk(1'b1, OP_ILL, 1'b1, C_IDLE, 1'b1, 1'b0, 4'd6, 1'b1, "il_trap "));
`else
        drive(mk(1'b0, OP_ILL, 1'b0, C_FETW, 1'b1, 1'b0, 4'd6, 1'b0, "il_nop  "));
`endif
        rst_pulse();

        // Store that never completes: timeout after WAIT_MAX idle cycles
        drive(mk(1'b1, OP_SW, 1'b0, C_IDLE, 1'b0, 1'b0, 4'd0, 1'b0, "to_idle "));
        drive(mk(1'b0, OP_SW, 1'b1, C_FETR, 1'b1, 1'b0, 4'd0, 1'b0, "to_fetch"));
        drive(mk(1'b0, OP_SW, 1'b0, C_DEC,  1'b1, 1'b0, 4'd0, 1'b0, "to_dec  "));
        drive(mk(1'b0, OP_SW, 1'b0, C_EXI,  1'b1, 1'b0, 4'd0, 1'b0, "to_addr "));
        for (int i = 0; i < 15; i++)
            drive(mk(1'b0, OP_SW, 1'b0, C_MWR, 1'b1, 1'b0, 4'd0, 1'b0, "to_wait "));
        drive(mk(1'b0, OP_SW,   1'b1, C_IDLE, 1'b0, 1'b1, 4'd0, 1'b0, "to_err  "));
        drive(mk(1'b1, OP_ADDI, 1'b0, C_IDLE, 1'b0, 1'b1, 4'd0, 1'b0, "to_start"));
        drive(mk(1'b0, OP_ADDI, 1'b0, C_FETW, 1'b1, 1'b0, 4'd0, 1'b0, "to_clear"));

        // Sixteen ADDIs wrap the 4-bit retired counter back to zero
        for (int i = 0; i < 16; i++) begin
            drive(mk(1'b0, OP_ADDI, 1'b1, C_FETR, 1'b1, 1'b0, 4'(i), 1'b0, "wr_fetch"));
            drive(mk(1'b0, OP_ADDI, 1'b0, C_DEC,  1'b1, 1'b0, 4'(i), 1'b0, "wr_dec  "));
            drive(mk(1'b0, OP_ADDI, 1'b0, C_EXI,  1'b1, 1'b0, 4'(i), 1'b0, "wr_exec "));
            drive(mk(1'b0, OP_ADDI, 1'b0, C_WBI,  1'b1, 1'b0, 4'(i), 1'b0, "wr_wb   "));
        end
        drive(mk(1'b0, OP_ADDI, 1'b0, C_FETW, 1'b1, 1'b0, 4'd0, 1'b0, "wr_zero "));

        // Reset asserted between clock edges while a load is outstanding
        drive(mk(1'b0, OP_LW, 1'b1, C_FETR, 1'b1, 1'b0, 4'd0, 1'b0, "m_fetch "));
        drive(mk(1'b0, OP_LW, 1'b0, C_DEC,  1'b1, 1'b0, 4'd0, 1'b0, "m_dec   "));
        drive(mk(1'b0, OP_LW, 1'b0, C_EXI,  1'b1, 1'b0, 4'd0, 1'b0, "m_addr  "));
        drive(mk(1'b0, OP_LW, 1'b0, C_MRD,  1'b1, 1'b0, 4'd0, 1'b0, "m_mrd   "));
        @(posedge clk_i);
        #1;
        mem_ready_i = 1'b0;
        #1;
        rst_i = 1'b1;
        #1;
        n_checks++;
        if ({ctl_s, busy_o, mem_err_o, retired_o, ill_s} !== 23'd0) begin
            n_fail++;
            $display("FAIL async_rst: got ctl=%h busy=%b err=%b ret=%0d ill=%b, expected all zero",
                     ctl_s, busy_o, mem_err_o, retired_o, ill_s);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        drive(mk(1'b0, OP_LW, 1'b1, C_IDLE, 1'b0, 1'b0, 4'd0, 1'b0, "post_rst"));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
